pattern_window_ctrl: RTL and testbench
======================================

Name: pattern_window_ctrl

Overview:
- Controller that runs one Mealy-style serial pattern detector over a bounded detection window and reports the hit count.
- Software or a higher-level FSM loads the pattern, its length, the overlap mode and the window length, then pulses start.
- The block samples one serial bit per clock for the window, flags every match with a Mealy output and counts matches.
- It then holds a done/ack handshake; it sits between the serial input source and the status/readout logic.

Parameters:
PAT_W, 8, maximum pattern length in bits
CNT_W, 8, width of the match counter
WIN_W, 16, width of the window-length field

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset (0 = reset)
start  in  1  begin a window; honoured only in IDLE
cfg_pattern  in  PAT_W  pattern; bit [L-1] is the first bit received, bit [0] the last
cfg_len  in  $clog2(PAT_W)+1  pattern length L
cfg_overlap  in  1  1 = overlapping detection, 0 = non-overlapping
win_len  in  WIN_W  number of serial bits to sample
in  in  1  serial data bit, sampled on each clk in RUN
match  out  1  Mealy match flag, combinational from in and history
match_count  out  CNT_W  matches in current/last window
busy  out  1  high in RUN
done  out  1  high in DONE until ack
ack  in  1  acknowledge done

Behaviour:
- Reset (reset=0, asynchronous, any state): state=IDLE; history, valid-count, bit counter and match_count cleared; busy=0, done=0, match=0.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - start=1 latches cfg_pattern, cfg_len, cfg_overlap and win_len, and clears history, valid-count, bit counter and match_count.
  - Next state is RUN, or DONE directly if win_len=0.
  - Config inputs are ignored outside this latch cycle.
- Length clamp: effective L = 1 if cfg_len=0; L = PAT_W if cfg_len>PAT_W.
- RUN, each cycle:
  - match = (valid-count >= L-1) AND ({history[L-2:0], in} == pattern[L-1:0]).
  - Match is Mealy: asserted in the same cycle the completing bit is on in.
  - On the clock edge: history shifts in `in`; valid-count increments, saturating at L-1; bit counter increments.
  - If match, match_count increments, saturating at 2^CNT_W-1.
- Overlap mode: history keeps shifting after a match (101 over 10101 gives 2 hits).
- Non-overlap mode: on a match, valid-count is cleared at that edge, so the next match needs L fresh bits.
- Window end: the edge that samples bit number win_len moves to DONE. Exactly win_len bits are sampled.
- match is forced to 0 outside RUN.
- DONE:
  - done=1, busy=0; match_count is held stable.
  - ack=1 returns to IDLE on the next edge; done falls the same edge.
  - match_count is retained until the next accepted start.
- start outside IDLE is ignored. start and ack together in DONE: ack honoured, start ignored (no restart).
- Latency: match 0 cycles; match_count updates 1 cycle after match; done rises 1 cycle after the last sampled bit.

Decomposition:
- Package pattern_window_pkg holds:
  - the state enum (IDLE, RUN, DONE);
  - default parameter constants;
  - a function clamping cfg_len to the range 1..PAT_W.
- Sub-module serial_pattern_match holds:
  - the history shift register, valid-count and Mealy compare;
  - ports clk, reset, clr, shift_en, in, pattern, len, overlap, match.
- The controller holds the FSM, bit counter, saturating match counter and handshake.

Test Plan:
- Overlap, pattern 101 (L=3), win_len=6, in=0,1,0,1,0,1 -> match high on bits 4 and 6, match_count=2, done one cycle after bit 6.
- Non-overlap, same stimulus -> match on bit 4 only, match_count=1.
- win_len=0, start -> DONE next cycle, match_count=0, match never asserted; ack -> IDLE.
- CNT_W=2, pattern 1 (L=1), win_len=6, in all 1s -> match every cycle, match_count saturates at 3.
- Reset driven low mid-RUN (after 3 bits) -> immediate IDLE, all outputs 0; new start runs a clean window with no leftover history.
- In DONE, assert start and ack together -> IDLE, no new window; start in RUN -> ignored, window length unchanged.

Source files
------------

// File: rtl/pattern_window_pkg.sv
// Shared types and helpers for the windowed serial pattern detector.
package pattern_window_pkg;

  localparam int unsigned PAT_W_DEF = 8;
  localparam int unsigned CNT_W_DEF = 8;
  localparam int unsigned WIN_W_DEF = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Map a requested pattern length onto the supported range 1..pat_w.
  function automatic int unsigned clamp_len(input int unsigned len, input int unsigned pat_w);
    if (len == 0) begin
      return 1;
    end else if (len > pat_w) begin
      return pat_w;
    end else begin
      return len;
    end
  endfunction

endpackage

// File: rtl/serial_pattern_match.sv
// Shift-register history with a Mealy compare of the newest L bits against the pattern.
module serial_pattern_match
  import pattern_window_pkg::*;
#(
  parameter int unsigned PAT_W = PAT_W_DEF
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   clr,
  input  logic                   shift_en,
  input  logic                   in,
  input  logic [PAT_W-1:0]       pattern,
  input  logic [$clog2(PAT_W):0] len,
  input  logic                   overlap,
  output logic                   match
);

  localparam int unsigned LEN_W = $clog2(PAT_W) + 1;

  logic [PAT_W-2:0] hist_q;
  logic [LEN_W-1:0] vcnt_q;
  logic [LEN_W-1:0] len_m1_c;
  logic [PAT_W-1:0] window_c;
  logic [PAT_W-1:0] mask_c;

  // len is already clamped to 1..PAT_W by the controller.
  always_comb begin
    len_m1_c = len - LEN_W'(1);
    window_c = {hist_q, in};
    mask_c   = '0;
    for (int i = 0; i < int'(PAT_W); i++) begin
      mask_c[i] = (LEN_W'(i) < len);
    end
  end

  assign match = shift_en && (vcnt_q >= len_m1_c) &&
                 (((window_c ^ pattern) & mask_c) == '0);

  // Non-overlap mode restarts the valid-bit count so the next hit needs L fresh bits.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hist_q <= '0;
      vcnt_q <= '0;
    end else if (clr) begin
      hist_q <= '0;
      vcnt_q <= '0;
    end else if (shift_en) begin
      hist_q <= window_c[PAT_W-2:0];
      if (match && !overlap) begin
        vcnt_q <= '0;
      end else if (vcnt_q < len_m1_c) begin
        vcnt_q <= vcnt_q + LEN_W'(1);
      end
    end
  end

endmodule

// File: rtl/pattern_window_ctrl.sv
// Runs the serial pattern matcher over a bounded window, counts hits and holds a done/ack handshake.
module pattern_window_ctrl
  import pattern_window_pkg::*;
#(
  parameter int unsigned PAT_W = PAT_W_DEF,
  parameter int unsigned CNT_W = CNT_W_DEF,
  parameter int unsigned WIN_W = WIN_W_DEF
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [PAT_W-1:0]       cfg_pattern,
  input  logic [$clog2(PAT_W):0] cfg_len,
  input  logic                   cfg_overlap,
  input  logic [WIN_W-1:0]       win_len,
  input  logic                   in,
  output logic                   match,
  output logic [CNT_W-1:0]       match_count,
  output logic                   busy,
  output logic                   done,
  input  logic                   ack
);

  localparam int unsigned LEN_W = $clog2(PAT_W) + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_e           state_q, state_d;
  logic [PAT_W-1:0] pattern_q;
  logic [LEN_W-1:0] len_q;
  logic             overlap_q;
  logic [WIN_W-1:0] win_q;
  logic [WIN_W-1:0] bit_cnt_q;
  logic [CNT_W-1:0] cnt_q;
  logic             accept_c;
  logic             run_c;
  logic             last_bit_c;
  logic             match_c;

  assign accept_c   = (state_q == IDLE) && start;
  assign run_c      = (state_q == RUN);
  assign last_bit_c = (bit_cnt_q == (win_q - WIN_W'(1)));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // A zero-length window skips RUN entirely.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = (win_len == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        if (last_bit_c) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (ack) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Config is captured only on an accepted start; counters restart there too.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pattern_q <= '0;
      len_q     <= LEN_W'(1);
      overlap_q <= 1'b0;
      win_q     <= '0;
      bit_cnt_q <= '0;
      cnt_q     <= '0;
    end else if (accept_c) begin
      pattern_q <= cfg_pattern;
      len_q     <= LEN_W'(clamp_len(32'(cfg_len), PAT_W));
      overlap_q <= cfg_overlap;
      win_q     <= win_len;
      bit_cnt_q <= '0;
      cnt_q     <= '0;
    end else if (run_c) begin
      bit_cnt_q <= bit_cnt_q + WIN_W'(1);
      if (match_c && (cnt_q != CNT_MAX)) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

  serial_pattern_match #(
    .PAT_W (PAT_W)
  ) u_match (
    .clk      (clk),
    .reset    (reset),
    .clr      (accept_c),
    .shift_en (run_c),
    .in       (in),
    .pattern  (pattern_q),
    .len      (len_q),
    .overlap  (overlap_q),
    .match    (match_c)
  );

  assign match       = match_c;
  assign match_count = cnt_q;
  assign busy        = (state_q == RUN);
  assign done        = (state_q == DONE);

endmodule

// File: tb/tb_pattern_window_ctrl.sv
// Directed bench for pattern_window_ctrl: table of windows plus reset/handshake corner sequences.
module tb_pattern_window_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [7:0]  cfg_pattern;
  logic [3:0]  cfg_len;
  logic        cfg_overlap;
  logic [15:0] win_len;
  logic        in;
  logic        ack;

  logic        match, busy, done;
  logic [7:0]  match_count;
  logic        s_match, s_busy, s_done;
  logic [1:0]  s_count;

  int errors = 0;
  int checks = 0;

  typedef struct {
    string       name;
    logic        overlap;
    logic [7:0]  pattern;
    logic [3:0]  len;
    logic [15:0] win;
    logic [15:0] bits;   // bit i = i-th serial bit sent
    logic [15:0] mmask;  // bit i = match expected while bit i is on in
    logic [7:0]  count;
  } vec_t;

  vec_t vecs[8];

  always #5 clk = ~clk;

  pattern_window_ctrl #(.PAT_W(8), .CNT_W(8), .WIN_W(16)) u_dut (
    .clk(clk), .reset(reset), .start(start), .cfg_pattern(cfg_pattern),
    .cfg_len(cfg_len), .cfg_overlap(cfg_overlap), .win_len(win_len), .in(in),
    .match(match), .match_count(match_count), .busy(busy), .done(done), .ack(ack)
  );

  pattern_window_ctrl #(.PAT_W(8), .CNT_W(2), .WIN_W(16)) u_sat (
    .clk(clk), .reset(reset), .start(start), .cfg_pattern(cfg_pattern),
    .cfg_len(cfg_len), .cfg_overlap(cfg_overlap), .win_len(win_len), .in(in),
    .match(s_match), .match_count(s_count), .busy(s_busy), .done(s_done), .ack(ack)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v);
    @(negedge clk);
    cfg_pattern = v.pattern;
    cfg_len     = v.len;
    cfg_overlap = v.overlap;
    win_len     = v.win;
    start       = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check({v.name, " busy_start"}, 32'(busy), 32'(v.win != 0));
    for (int i = 0; i < int'(v.win); i++) begin
      in = v.bits[i];
      #1;
      check($sformatf("%s match[%0d]", v.name, i), 32'(match), 32'(v.mmask[i]));
      @(negedge clk);
    end
    check({v.name, " done"}, 32'(done), 32'(1));
    check({v.name, " busy_end"}, 32'(busy), 32'(0));
    check({v.name, " match_in_done"}, 32'(match), 32'(0));
    check({v.name, " count"}, 32'(match_count), 32'(v.count));
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
    check({v.name, " done_after_ack"}, 32'(done), 32'(0));
    check({v.name, " count_retained"}, 32'(match_count), 32'(v.count));
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; ack = 1'b0; in = 1'b0;
    cfg_pattern = '0; cfg_len = '0; cfg_overlap = 1'b0; win_len = '0;

    vecs[0] = '{"ov101", 1'b1, 8'h05, 4'd3,  16'd6,  16'h002A, 16'h0028, 8'd2};
    vecs[1] = '{"no101", 1'b0, 8'h05, 4'd3,  16'd6,  16'h002A, 16'h0008, 8'd1};
    vecs[2] = '{"win0",  1'b1, 8'h05, 4'd3,  16'd0,  16'h0000, 16'h0000, 8'd0};
    vecs[3] = '{"len0",  1'b0, 8'h01, 4'd0,  16'd4,  16'h000D, 16'h000D, 8'd3};
    vecs[4] = '{"len15", 1'b1, 8'hA5, 4'd15, 16'd10, 16'h01A5, 16'h0080, 8'd1};
    vecs[5] = '{"ov11",  1'b1, 8'h03, 4'd2,  16'd4,  16'h000F, 16'h000E, 8'd3};
    vecs[6] = '{"no11",  1'b0, 8'h03, 4'd2,  16'd4,  16'h000F, 16'h000A, 8'd2};
    vecs[7] = '{"sat1",  1'b1, 8'h01, 4'd1,  16'd6,  16'h003F, 16'h003F, 8'd6};

    repeat (2) @(negedge clk);
    check("rst busy",  32'(busy),        32'(0));
    check("rst done",  32'(done),        32'(0));
    check("rst match", 32'(match),       32'(0));
    check("rst count", 32'(match_count), 32'(0));
    reset = 1'b1;

    for (int k = 0; k < 8; k++) begin
      run_vec(vecs[k]);
    end
    // Narrow counter instance saw the all-ones window too.
    check("sat count_cnt2", 32'(s_count), 32'(3));
    check("sat done_cnt2",  32'(s_done),  32'(0));

    // Reset mid-RUN after three bits (1,0,1 already produced one hit).
    @(negedge clk);
    cfg_pattern = 8'h05; cfg_len = 4'd3; cfg_overlap = 1'b1; win_len = 16'd6; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in = (i != 1);
      @(negedge clk);
    end
    check("midrun busy_pre",  32'(busy),        32'(1));
    check("midrun count_pre", 32'(match_count), 32'(1));
    in = 1'b1;
    reset = 1'b0;
    #1;
    check("midrun busy",  32'(busy),        32'(0));
    check("midrun done",  32'(done),        32'(0));
    check("midrun match", 32'(match),       32'(0));
    check("midrun count", 32'(match_count), 32'(0));
    @(negedge clk);
    reset = 1'b1;
    run_vec('{"postrst", 1'b1, 8'h05, 4'd3, 16'd3, 16'h0005, 16'h0004, 8'd1});

    // start and ack together in DONE: ack wins, no restart.
    @(negedge clk);
    win_len = 16'd0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("sa done", 32'(done), 32'(1));
    win_len = 16'd6; start = 1'b1; ack = 1'b1;
    @(negedge clk);
    start = 1'b0; ack = 1'b0;
    check("sa done_low", 32'(done), 32'(0));
    check("sa busy_low", 32'(busy), 32'(0));
    @(negedge clk);
    check("sa no_restart", 32'(busy), 32'(0));

    // start in RUN with different config is ignored; window stays 4 bits of "11".
    cfg_pattern = 8'h03; cfg_len = 4'd2; cfg_overlap = 1'b1; win_len = 16'd4; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in = 1'b1;
      start = (i == 1);
      if (i == 1) begin
        cfg_pattern = 8'h00; cfg_len = 4'd1; win_len = 16'd2;
      end
      #1;
      check($sformatf("runstart match[%0d]", i), 32'(match), 32'(i >= 1));
      if (i == 3) check("runstart busy_late", 32'(busy), 32'(1));
      @(negedge clk);
    end
    start = 1'b0;
    check("runstart done",  32'(done),        32'(1));
    check("runstart count", 32'(match_count), 32'(3));
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
    check("runstart idle", 32'(done | busy), 32'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
